// File: rtl/mod_bram_loader.sv
// ---------------------------------------------------------------------------
// mod_bram_loader
//   Writer side of the double-buffered modulation memory. 16-bit words from
//   the CPU-side stream are split into two bytes and written one per cycle to
//   the byte-wide mod BRAM, always into the inactive segment. When the final
//   word has been written, the new length (CYCLE), the segment flip and the
//   checksum are committed together in one cycle, so the modulator never sees
//   a half-updated buffer.
//
// Build option:
//   MOD_BRAM_LOADER_CHECKSUM_EN  - when defined, an 8-bit running sum of the
//                                  written bytes is latched to CHECKSUM on
//                                  commit; otherwise CHECKSUM is tied to 0.
//
// Ports:
//   CLK       system clock (20.48 MHz domain)
//   RST_N     synchronous active-low reset
//   WR_VALID  input word valid
//   WR_READY  loader accepts a word this cycle
//   WR_DATA   [7:0] first byte, [15:8] second byte
//   WR_LAST   word is the last of the transfer
//   WR_ODD    with WR_LAST: only WR_DATA[7:0] is valid
//   MOD_WE    BRAM byte write enable
//   MOD_ADDR  {segment, byte address}
//   MOD_DIN   BRAM write byte
//   SEGMENT   active (readable) segment
//   CYCLE     committed length in bytes minus 1
//   DONE      one-cycle pulse at the end of a transfer
//   ERR       overflow in the last/current transfer
//   CHECKSUM  sum mod 256 of the committed bytes
// ---------------------------------------------------------------------------
module mod_bram_loader #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [15:0]           WR_DATA,
    input  logic                  WR_LAST,
    input  logic                  WR_ODD,
    output logic                  MOD_WE,
    output logic [ADDR_WIDTH:0]   MOD_ADDR,
    output logic [7:0]            MOD_DIN,
    output logic                  SEGMENT,
    output logic [ADDR_WIDTH-1:0] CYCLE,
    output logic                  DONE,
    output logic                  ERR,
    output logic [7:0]            CHECKSUM
);

    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] CYC_ONE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LO     = 2'd1,
        HI     = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic [7:0]            hi_byte_q, hi_byte_n;
    logic                  last_q, last_n;
    logic                  odd_q, odd_n;
    logic                  in_xfer_q, in_xfer_n;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_n, cnt_base;
    logic                  err_q, err_n, err_base;
    logic                  seg_q, seg_n;
    logic [ADDR_WIDTH-1:0] cycle_q, cycle_n;
    logic                  rdy_q, rdy_n;
    logic                  we_q, we_n;
    logic [7:0]            din_q, din_n;
    logic [ADDR_WIDTH:0]   addr_q, addr_n;
    logic                  done_q, done_n;

    logic                  accept;
    logic                  load;
    logic                  first;
    logic                  wr_byte;
    logic                  wr_fire;
    logic                  go_commit;
    logic                  commit_ok;
    logic [7:0]            byte_sel;

    // Every output is a register; the combinational block below computes
    // the value each output takes in the cycle after the state decision.
    always_comb begin
        state_n   = state_q;
        hi_byte_n = hi_byte_q;
        last_n    = last_q;
        odd_n     = odd_q;
        in_xfer_n = in_xfer_q;
        cnt_n     = cnt_q;
        err_n     = err_q;
        seg_n     = seg_q;
        cycle_n   = cycle_q;
        we_n      = 1'b0;
        din_n     = din_q;
        addr_n    = addr_q;
        done_n    = 1'b0;
        load      = 1'b0;
        wr_byte   = 1'b0;
        go_commit = 1'b0;
        byte_sel  = 8'h00;

        accept = WR_VALID & rdy_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_n = LO;
                end
            end
            LO: begin
                if (last_q && odd_q) begin
                    go_commit = 1'b1;
                    state_n   = COMMIT;
                end else begin
                    wr_byte  = 1'b1;
                    byte_sel = hi_byte_q;
                    state_n  = HI;
                end
            end
            HI: begin
                if (last_q) begin
                    go_commit = 1'b1;
                    state_n   = COMMIT;
                end else if (accept) begin
                    load    = 1'b1;
                    state_n = LO;
                end else begin
                    state_n = IDLE;
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Accepting a word schedules its low byte for the very next cycle.
        if (load) begin
            hi_byte_n = WR_DATA[15:8];
            last_n    = WR_LAST;
            odd_n     = WR_ODD;
            in_xfer_n = 1'b1;
            wr_byte   = 1'b1;
            byte_sel  = WR_DATA[7:0];
        end

        // A word arriving outside a transfer starts a new one. IDLE can also
        // be reached mid-transfer when the source stalls, hence the flag.
        first    = load & ~in_xfer_q;
        cnt_base = first ? '0 : cnt_q;
        err_base = first ? 1'b0 : err_q;

        // The counter saturates at 2**ADDR_WIDTH; a byte arriving there is
        // the overflow and nothing further is written in this transfer.
        wr_fire = wr_byte & ~err_base & ~cnt_base[ADDR_WIDTH];
        cnt_n   = cnt_base;
        err_n   = err_base;
        if (wr_byte) begin
            if (wr_fire) begin
                we_n   = 1'b1;
                din_n  = byte_sel;
                addr_n = {~seg_q, cnt_base[ADDR_WIDTH-1:0]};
                cnt_n  = cnt_base + CNT_ONE;
            end else begin
                err_n = 1'b1;
            end
        end

        // Commit is visible together with DONE. A full segment leaves the
        // low counter bits at zero, so the wrap gives CYCLE = all ones.
        commit_ok = go_commit & ~err_q;
        if (go_commit) begin
            done_n    = 1'b1;
            in_xfer_n = 1'b0;
        end
        if (commit_ok) begin
            seg_n   = ~seg_q;
            cycle_n = cnt_q[ADDR_WIDTH-1:0] - CYC_ONE;
        end

        rdy_n = (state_n == IDLE) || ((state_n == HI) && !last_n);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            odd_q     <= 1'b0;
            in_xfer_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            seg_q     <= 1'b0;
            cycle_q   <= '0;
            rdy_q     <= 1'b0;
            we_q      <= 1'b0;
            din_q     <= 8'h00;
            addr_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            last_q    <= last_n;
            odd_q     <= odd_n;
            in_xfer_q <= in_xfer_n;
            cnt_q     <= cnt_n;
            err_q     <= err_n;
            seg_q     <= seg_n;
            cycle_q   <= cycle_n;
            rdy_q     <= rdy_n;
            we_q      <= we_n;
            din_q     <= din_n;
            addr_q    <= addr_n;
            done_q    <= done_n;
        end
    end

    // Second byte of the current word; only meaningful while a word is held.
    always_ff @(posedge CLK) begin
        hi_byte_q <= hi_byte_n;
    end

`ifdef MOD_BRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_base;
    logic [7:0] chk_q;

    assign sum_base = first ? 8'h00 : sum_q;

    // Write and commit never coincide, so sum_q is final when committed.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sum_q <= 8'h00;
            chk_q <= 8'h00;
        end else begin
            if (wr_fire) begin
                sum_q <= sum_base + byte_sel;
            end else begin
                sum_q <= sum_base;
            end
            if (commit_ok) begin
                chk_q <= sum_q;
            end
        end
    end

    assign CHECKSUM = chk_q;
`else
    assign CHECKSUM = 8'h00;
`endif

    assign WR_READY = rdy_q;
    assign MOD_WE   = we_q;
    assign MOD_ADDR = addr_q;
    assign MOD_DIN  = din_q;
    assign SEGMENT  = seg_q;
    assign CYCLE    = cycle_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_mod_bram_loader.sv
// ---------------------------------------------------------------------------
// tb_mod_bram_loader
//   Scoreboard bench for mod_bram_loader with a 16-byte segment
//   (ADDR_WIDTH = 4), so MOD_ADDR bit 4 is the segment bit. Stimulus pushes
//   the hand-computed BRAM writes and commit results into queues; a monitor
//   on the falling edge pops and compares on every MOD_WE and DONE.
// ---------------------------------------------------------------------------
module tb_mod_bram_loader;

    localparam int AW = 4;

`ifdef MOD_BRAM_LOADER_CHECKSUM_EN
    localparam logic [7:0] CHK_MASK = 8'hFF;
`else
    localparam logic [7:0] CHK_MASK = 8'h00;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          WR_VALID = 1'b0;
    logic          WR_READY;
    logic [15:0]   WR_DATA = 16'h0000;
    logic          WR_LAST = 1'b0;
    logic          WR_ODD = 1'b0;
    logic          MOD_WE;
    logic [AW:0]   MOD_ADDR;
    logic [7:0]    MOD_DIN;
    logic          SEGMENT;
    logic [AW-1:0] CYCLE;
    logic          DONE;
    logic          ERR;
    logic [7:0]    CHECKSUM;

    mod_bram_loader #(.ADDR_WIDTH(AW)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .WR_VALID (WR_VALID),
        .WR_READY (WR_READY),
        .WR_DATA  (WR_DATA),
        .WR_LAST  (WR_LAST),
        .WR_ODD   (WR_ODD),
        .MOD_WE   (MOD_WE),
        .MOD_ADDR (MOD_ADDR),
        .MOD_DIN  (MOD_DIN),
        .SEGMENT  (SEGMENT),
        .CYCLE    (CYCLE),
        .DONE     (DONE),
        .ERR      (ERR),
        .CHECKSUM (CHECKSUM)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic          seg;
        logic [AW-1:0] cycle;
        logic          err;
        logic [7:0]    chk;
    } cm_t;

    wr_t exp_wr[$];
    cm_t exp_cm[$];

    int n_pass   = 0;
    int n_total  = 0;
    int done_cnt = 0;
    int we_run   = 0;
    int last_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_wr(input logic [AW:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_cm(input logic s, input logic [AW-1:0] c, input logic e, input logic [7:0] k);
        cm_t m;
        m.seg   = s;
        m.cycle = c;
        m.err   = e;
        m.chk   = k & CHK_MASK;
        exp_cm.push_back(m);
    endtask

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic send_word(input logic [15:0] d, input logic l, input logic o, output int waits);
        waits    = 0;
        WR_VALID = 1'b1;
        WR_DATA  = d;
        WR_LAST  = l;
        WR_ODD   = o;
        while (WR_READY !== 1'b1 && waits < 50) begin
            @(negedge CLK);
            waits++;
        end
        if (waits >= 50) begin
            check("ready_timeout", 32'(WR_READY), 32'd1);
            WR_VALID = 1'b0;
        end else begin
            @(negedge CLK);
        end
    endtask

    task automatic wait_done(input int n);
        int g;
        g = 0;
        while (done_cnt < n && g < 100) begin
            @(posedge CLK);
            g++;
        end
        check("done_count", 32'(done_cnt), 32'(n));
        @(negedge CLK);
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        wr_t w;
        cm_t m;
        if (!RST_N) begin
            we_run = 0;
        end else begin
            if (MOD_WE) begin
                we_run++;
                check("write_pending", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(MOD_ADDR), 32'(w.addr));
                    check("wr_data", 32'(MOD_DIN), 32'(w.data));
                end
            end else begin
                if (we_run != 0) last_run = we_run;
                we_run = 0;
            end
            if (DONE) begin
                done_cnt++;
                check("commit_pending", 32'(exp_cm.size() != 0), 32'd1);
                if (exp_cm.size() != 0) begin
                    m = exp_cm.pop_front();
                    check("commit_segment", 32'(SEGMENT), 32'(m.seg));
                    check("commit_cycle", 32'(CYCLE), 32'(m.cycle));
                    check("commit_err", 32'(ERR), 32'(m.err));
                    check("commit_checksum", 32'(CHECKSUM), 32'(m.chk));
                end
            end
        end
    end

    initial begin
        int w;
        int nd;
        nd = 0;

        // Reset held for four cycles: every output low.
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("reset_outputs",
                  32'({WR_READY, MOD_WE, MOD_ADDR, MOD_DIN, SEGMENT, CYCLE, DONE, ERR, CHECKSUM}),
                  32'd0);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        check("ready_after_reset", 32'(WR_READY), 32'd1);

        // Three words into segment 1 (SEGMENT=0).
        for (int k = 0; k < 6; k++) push_wr(5'h10 + 5'(k), 8'h01 + 8'(k));
        push_cm(1'b1, 4'h5, 1'b0, 8'h15);
        send_word(16'h0201, 1'b0, 1'b0, w);
        send_word(16'h0403, 1'b0, 1'b0, w);
        send_word(16'h0605, 1'b1, 1'b0, w);
        WR_VALID = 1'b0;
        nd++;
        wait_done(nd);

        // Odd last word: only its low byte is written.
        push_wr(5'h00, 8'h09);
        push_wr(5'h01, 8'h0A);
        push_wr(5'h02, 8'h0B);
        push_cm(1'b0, 4'h2, 1'b0, 8'h1E);
        send_word(16'h0A09, 1'b0, 1'b0, w);
        send_word(16'h000B, 1'b1, 1'b1, w);
        WR_VALID = 1'b0;
        nd++;
        wait_done(nd);

        // WR_VALID held for four words: ready alternates, writes back to back.
        for (int k = 0; k < 8; k++) push_wr(5'h10 + 5'(k), 8'h11 + 8'(k));
        push_cm(1'b1, 4'h7, 1'b0, 8'hA4);
        send_word(16'h1211, 1'b0, 1'b0, w);
        check("ready_w1", 32'(w), 32'd0);
        send_word(16'h1413, 1'b0, 1'b0, w);
        check("ready_w2", 32'(w), 32'd1);
        send_word(16'h1615, 1'b0, 1'b0, w);
        check("ready_w3", 32'(w), 32'd1);
        send_word(16'h1817, 1'b1, 1'b0, w);
        check("ready_w4", 32'(w), 32'd1);
        WR_VALID = 1'b0;
        nd++;
        wait_done(nd);
        check("we_burst_len", 32'(last_run), 32'd8);

        push_wr(5'h00, 8'h21);
        push_wr(5'h01, 8'h22);
        push_cm(1'b0, 4'h1, 1'b0, 8'h43);
        send_word(16'h2221, 1'b1, 1'b0, w);
        WR_VALID = 1'b0;
        nd++;
        wait_done(nd);

        // Overflow: 9 words = 18 bytes into a 16-byte segment.
        for (int k = 0; k < 16; k++) push_wr(5'h10 + 5'(k), 8'h40 + 8'(k));
        push_cm(1'b0, 4'h1, 1'b1, 8'h43);
        for (int i = 0; i < 9; i++)
            send_word({8'h41 + 8'(2 * i), 8'h40 + 8'(2 * i)}, 1'(i == 8), 1'b0, w);
        WR_VALID = 1'b0;
        nd++;
        wait_done(nd);
        check("err_holds", 32'(ERR), 32'd1);

        // Exactly full segment: legal, CYCLE all ones, ERR cleared.
        for (int k = 0; k < 16; k++) push_wr(5'h10 + 5'(k), 8'h40 + 8'(k));
        push_cm(1'b1, 4'hF, 1'b0, 8'h78);
        for (int i = 0; i < 8; i++)
            send_word({8'h41 + 8'(2 * i), 8'h40 + 8'(2 * i)}, 1'(i == 7), 1'b0, w);
        WR_VALID = 1'b0;
        nd++;
        wait_done(nd);
        check("err_cleared", 32'(ERR), 32'd0);

        // Reset in the middle of a transfer: nothing committed.
        push_wr(5'h00, 8'h31);
        push_wr(5'h01, 8'h32);
        send_word(16'h3231, 1'b0, 1'b0, w);
        WR_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("midreset_segment", 32'(SEGMENT), 32'd0);
        check("midreset_cycle", 32'(CYCLE), 32'd0);
        check("midreset_no_done", 32'(done_cnt), 32'(nd));

        // Fresh transfer after reset starts at byte 0.
        push_wr(5'h10, 8'h41);
        push_wr(5'h11, 8'h42);
        push_cm(1'b1, 4'h1, 1'b0, 8'h83);
        send_word(16'h4241, 1'b1, 1'b0, w);
        WR_VALID = 1'b0;
        nd++;
        wait_done(nd);

        repeat (3) @(negedge CLK);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("cm_queue_empty", 32'(exp_cm.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
